hls_activity_monitor: RTL and testbench

//  Synthesizable performance monitor for one HLS-generated block and one of its loops.

---
 rtl/hls_activity_monitor_pkg.sv | 18 +
 rtl/hls_activity_monitor_if.sv | 14 +
 rtl/hls_activity_monitor_sat_counter.sv | 44 ++++
 rtl/hls_activity_monitor.sv | 153 +++++++++++++++
 tb/tb_hls_activity_monitor.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hls_activity_monitor_pkg.sv
// Shared types and constants for the HLS activity monitor.
// Holds the FSM state enums, the default widths and the one-hot state match helper.
package hls_activity_mon_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int STATE_W_DEF = 7;
    localparam int MATCH_W     = 32;

    typedef enum logic {MS_IDLE, MS_BUSY} mod_state_e;
    typedef enum logic {LS_IDLE, LS_ACTIVE} loop_state_e;

    // A non-one-hot cur_state simply matches whenever any bit overlaps the reference.
    function automatic logic state_match(input logic [MATCH_W-1:0] cur_state,
                                         input logic [MATCH_W-1:0] ref_state);
        return |(cur_state & ref_state);
    endfunction

endpackage

// File: rtl/hls_activity_monitor_if.sv
// Block-level ap_* handshake of the monitored HLS block.
// The monitored block (or a bench) drives through master; the monitor observes through slave.
interface hls_activity_monitor_if;
    import hls_activity_mon_pkg::*;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (output ap_start, output ap_ready, output ap_done, output ap_continue);
    modport slave  (input  ap_start, input  ap_ready, input  ap_done, input  ap_continue);

endinterface

// File: rtl/hls_activity_monitor_sat_counter.sv
// Saturating up-counter used for every monitor statistic.
// sat goes high on an increment attempted at all-ones and stays high until reset.
module sat_counter
    import hls_activity_mon_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         freeze,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (inc && !freeze) begin
            if (&count_q) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/hls_activity_monitor.sv
// Passive performance monitor for an HLS block and one of its loops.
// Define HLS_ACTIVITY_MON_STALL_EN to build the start-state stall counter.
module hls_activity_monitor
    import hls_activity_mon_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 finish,
    hls_activity_monitor_if.slave ap,
    input  logic [STATE_W-1:0]   cur_state,
    input  logic [STATE_W-1:0]   iter_start_state,
    input  logic [STATE_W-1:0]   iter_end_state,
    input  logic [STATE_W-1:0]   quit_state,
    input  logic                 iter_start_block,
    input  logic                 iter_end_block,
    input  logic                 quit_block,
    input  logic                 iter_start_enable,
    input  logic                 iter_end_enable,
    input  logic                 quit_enable,
    input  logic                 loop_start,
    input  logic                 loop_ready,
    input  logic                 loop_done,
    input  logic                 loop_continue,
    input  logic                 quit_at_end,
    output logic                 module_busy,
    output logic [CNT_W-1:0]     txn_count,
    output logic [CNT_W-1:0]     busy_cycles,
    output logic                 loop_active,
    output logic [CNT_W-1:0]     loop_count,
    output logic [CNT_W-1:0]     iter_count,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic                 overflow
);

    mod_state_e  mod_state_q, mod_state_d;
    loop_state_e loop_state_q, loop_state_d;
    logic        frozen_q, frozen_d;
    logic        freeze;
    logic        done_evt, loop_done_evt;
    logic        end_evt, quit_evt, iter_inc;
    logic        txn_sat, busy_sat, loop_sat, iter_sat, stall_sat;
    logic        unused_ok;

    assign unused_ok = &{1'b0, ap.ap_ready, loop_ready};

    // finish takes effect in the cycle it is sampled, so nothing from that cycle is counted.
    assign freeze   = finish | frozen_q;
    assign frozen_d = freeze;

    always_comb begin
        mod_state_d = mod_state_q;
        done_evt    = 1'b0;
        case (mod_state_q)
            MS_IDLE: begin
                if (ap.ap_start) mod_state_d = MS_BUSY;
            end
            MS_BUSY: begin
                if (ap.ap_done && ap.ap_continue) begin
                    done_evt = 1'b1;
                    if (!ap.ap_start) mod_state_d = MS_IDLE;
                end
            end
            default: mod_state_d = MS_IDLE;
        endcase
        if (freeze) mod_state_d = mod_state_q;
    end

    always_comb begin
        loop_state_d  = loop_state_q;
        loop_done_evt = 1'b0;
        case (loop_state_q)
            LS_IDLE: begin
                if (loop_start) loop_state_d = LS_ACTIVE;
            end
            LS_ACTIVE: begin
                if (loop_done && loop_continue) begin
                    loop_done_evt = 1'b1;
                    if (!loop_start) loop_state_d = LS_IDLE;
                end
            end
            default: loop_state_d = LS_IDLE;
        endcase
        if (freeze) loop_state_d = loop_state_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mod_state_q  <= MS_IDLE;
            loop_state_q <= LS_IDLE;
            frozen_q     <= 1'b0;
        end else begin
            mod_state_q  <= mod_state_d;
            loop_state_q <= loop_state_d;
            frozen_q     <= frozen_d;
        end
    end

    assign module_busy = (mod_state_q == MS_BUSY);
    assign loop_active = (loop_state_q == LS_ACTIVE);

    always_comb begin
        end_evt  = loop_active & state_match(MATCH_W'(cur_state), MATCH_W'(iter_end_state))
                   & ~iter_end_block & iter_end_enable;
        quit_evt = loop_active & state_match(MATCH_W'(cur_state), MATCH_W'(quit_state))
                   & ~quit_block & quit_enable;
        iter_inc = end_evt | (quit_evt & quit_at_end);
    end

    sat_counter #(.W(CNT_W)) u_txn (
        .clock(clock), .reset(reset), .inc(done_evt), .freeze(freeze),
        .count(txn_count), .sat(txn_sat)
    );

    sat_counter #(.W(CNT_W)) u_busy (
        .clock(clock), .reset(reset), .inc(module_busy), .freeze(freeze),
        .count(busy_cycles), .sat(busy_sat)
    );

    sat_counter #(.W(CNT_W)) u_loop (
        .clock(clock), .reset(reset), .inc(loop_done_evt), .freeze(freeze),
        .count(loop_count), .sat(loop_sat)
    );

    sat_counter #(.W(CNT_W)) u_iter (
        .clock(clock), .reset(reset), .inc(iter_inc), .freeze(freeze),
        .count(iter_count), .sat(iter_sat)
    );

`ifdef HLS_ACTIVITY_MON_STALL_EN
    logic stall_inc;

    assign stall_inc = loop_active
                       & state_match(MATCH_W'(cur_state), MATCH_W'(iter_start_state))
                       & iter_start_enable & iter_start_block;

    sat_counter #(.W(CNT_W)) u_stall (
        .clock(clock), .reset(reset), .inc(stall_inc), .freeze(freeze),
        .count(stall_cycles), .sat(stall_sat)
    );
`else
    logic unused_stall;

    assign unused_stall = &{1'b0, iter_start_state, iter_start_enable, iter_start_block};
    assign stall_cycles = '0;
    assign stall_sat    = 1'b0;
`endif

    assign overflow = txn_sat | busy_sat | loop_sat | iter_sat | stall_sat;

endmodule

// File: tb/tb_hls_activity_monitor.sv
// Directed self-checking bench for hls_activity_monitor: a 32-bit instance for function
// and a 4-bit instance for saturation.
module tb_hls_activity_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        finish;
    logic [6:0]  cur_state, iter_start_state, iter_end_state, quit_state;
    logic        iter_start_block, iter_end_block, quit_block;
    logic        iter_start_enable, iter_end_enable, quit_enable;
    logic        loop_start, loop_ready, loop_done, loop_continue, quit_at_end;

    logic        module_busy, loop_active, overflow;
    logic [31:0] txn_count, busy_cycles, loop_count, iter_count, stall_cycles;
    logic        s_module_busy, s_loop_active, s_overflow;
    logic [3:0]  s_txn_count, s_busy_cycles, s_loop_count, s_iter_count, s_stall_cycles;

    int checks = 0;
    int errors = 0;

    hls_activity_monitor_if ap_m ();
    hls_activity_monitor_if ap_s ();

    always #5 clock = ~clock;

    hls_activity_monitor #(.STATE_W(7), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .finish(finish), .ap(ap_m),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
        .quit_block(quit_block), .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .module_busy(module_busy), .txn_count(txn_count), .busy_cycles(busy_cycles),
        .loop_active(loop_active), .loop_count(loop_count), .iter_count(iter_count),
        .stall_cycles(stall_cycles), .overflow(overflow)
    );

    hls_activity_monitor #(.STATE_W(7), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .finish(finish), .ap(ap_s),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
        .quit_block(quit_block), .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .module_busy(s_module_busy), .txn_count(s_txn_count), .busy_cycles(s_busy_cycles),
        .loop_active(s_loop_active), .loop_count(s_loop_count), .iter_count(s_iter_count),
        .stall_cycles(s_stall_cycles), .overflow(s_overflow)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_inputs();
        finish = 1'b0;
        ap_m.ap_start = 1'b0; ap_m.ap_ready = 1'b0; ap_m.ap_done = 1'b0; ap_m.ap_continue = 1'b1;
        ap_s.ap_start = 1'b0; ap_s.ap_ready = 1'b0; ap_s.ap_done = 1'b0; ap_s.ap_continue = 1'b1;
        cur_state = '0; iter_start_state = '0; iter_end_state = '0; quit_state = '0;
        iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0;
        iter_start_enable = 1'b0; iter_end_enable = 1'b0; quit_enable = 1'b0;
        loop_start = 1'b0; loop_ready = 1'b0; loop_done = 1'b0; loop_continue = 1'b1;
        quit_at_end = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({module_busy, loop_active, overflow, txn_count, busy_cycles, loop_count,
             iter_count, stall_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_main got busy=%b active=%b ovf=%b txn=%0d busy_cyc=%0d loop=%0d iter=%0d stall=%0d required all 0",
                     module_busy, loop_active, overflow, txn_count, busy_cycles, loop_count,
                     iter_count, stall_cycles);
        end
        checks++;
        if ({s_module_busy, s_loop_active, s_overflow, s_txn_count, s_busy_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_small got txn=%0d busy_cyc=%0d ovf=%b required 0",
                     s_txn_count, s_busy_cycles, s_overflow);
        end
    endtask

    task automatic test_single_txn();
        do_reset();
        ap_m.ap_start = 1'b1;
        tick();
        ap_m.ap_start = 1'b0;
        checks++;
        if (module_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_flag got %b required 1", module_busy);
        end
        tick(5);
        ap_m.ap_done = 1'b1;
        tick();
        ap_m.ap_done = 1'b0;
        tick(2);
        checks++;
        if (txn_count !== 32'd1) begin
            errors++;
            $display("FAIL single_txn_count got %0d required 1", txn_count);
        end
        checks++;
        if (busy_cycles !== 32'd6) begin
            errors++;
            $display("FAIL single_busy_cycles got %0d required 6", busy_cycles);
        end
        checks++;
        if (module_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_after got %b required 0", module_busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ap_m.ap_start = 1'b1;
        tick();
        ap_m.ap_start = 1'b0;
        tick(2);
        ap_m.ap_done = 1'b1;
        ap_m.ap_start = 1'b1;
        tick();
        ap_m.ap_done = 1'b0;
        ap_m.ap_start = 1'b0;
        checks++;
        if (module_busy !== 1'b1 || txn_count !== 32'd1) begin
            errors++;
            $display("FAIL b2b_first got busy=%b txn=%0d required busy=1 txn=1", module_busy, txn_count);
        end
        tick(2);
        ap_m.ap_done = 1'b1;
        tick();
        ap_m.ap_done = 1'b0;
        checks++;
        if (txn_count !== 32'd2 || busy_cycles !== 32'd6 || module_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got txn=%0d busy_cyc=%0d busy=%b required txn=2 busy_cyc=6 busy=0",
                     txn_count, busy_cycles, module_busy);
        end
    endtask

    task automatic test_continue();
        ap_m.ap_start = 1'b1;
        tick();
        ap_m.ap_start = 1'b0;
        ap_m.ap_done = 1'b1;
        ap_m.ap_continue = 1'b0;
        tick();
        checks++;
        if (module_busy !== 1'b1 || txn_count !== 32'd2) begin
            errors++;
            $display("FAIL continue_held got busy=%b txn=%0d required busy=1 txn=2", module_busy, txn_count);
        end
        ap_m.ap_continue = 1'b1;
        tick();
        ap_m.ap_done = 1'b0;
        checks++;
        if (module_busy !== 1'b0 || txn_count !== 32'd3) begin
            errors++;
            $display("FAIL continue_release got busy=%b txn=%0d required busy=0 txn=3", module_busy, txn_count);
        end
    endtask

    task automatic test_pipelined_loop();
        do_reset();
        iter_end_state = 7'b0000001;
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        checks++;
        if (loop_active !== 1'b1) begin
            errors++;
            $display("FAIL loop_active_set got %b required 1", loop_active);
        end
        cur_state = 7'b0000001;
        iter_end_enable = 1'b1;
        tick(256);
        iter_end_enable = 1'b0;
        cur_state = '0;
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        checks++;
        if (iter_count !== 32'd256 || loop_count !== 32'd1 || loop_active !== 1'b0) begin
            errors++;
            $display("FAIL loop_256 got iter=%0d loop=%0d active=%b required iter=256 loop=1 active=0",
                     iter_count, loop_count, loop_active);
        end
        cur_state = 7'b0000001;
        iter_end_enable = 1'b1;
        tick(3);
        iter_end_enable = 1'b0;
        cur_state = '0;
        checks++;
        if (iter_count !== 32'd256) begin
            errors++;
            $display("FAIL loop_inactive_ignored got %0d required 256", iter_count);
        end
    endtask

    task automatic test_quit_at_end();
        do_reset();
        iter_end_state = 7'b0000010;
        quit_state = 7'b0000010;
        quit_at_end = 1'b1;
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        cur_state = 7'b0000010;
        iter_end_enable = 1'b1;
        tick(2);
        iter_end_block = 1'b1;
        tick();
        iter_end_block = 1'b0;
        checks++;
        if (iter_count !== 32'd2) begin
            errors++;
            $display("FAIL quit_blocked_end got %0d required 2", iter_count);
        end
        quit_enable = 1'b1;
        tick();
        checks++;
        if (iter_count !== 32'd3) begin
            errors++;
            $display("FAIL quit_coincident_once got %0d required 3", iter_count);
        end
        iter_end_enable = 1'b0;
        quit_at_end = 1'b0;
        quit_state = 7'b0000100;
        cur_state = 7'b0000100;
        tick();
        checks++;
        if (iter_count !== 32'd3) begin
            errors++;
            $display("FAIL quit_only_noend got %0d required 3", iter_count);
        end
        quit_at_end = 1'b1;
        tick();
        quit_enable = 1'b0;
        checks++;
        if (iter_count !== 32'd4) begin
            errors++;
            $display("FAIL quit_only_atend got %0d required 4", iter_count);
        end
        cur_state = '0;
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] exp_stall;
`ifdef HLS_ACTIVITY_MON_STALL_EN
        exp_stall = 32'd3;
`else
        exp_stall = 32'd0;
`endif
        do_reset();
        iter_start_state = 7'b0001000;
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        cur_state = 7'b0001000;
        iter_start_enable = 1'b1;
        iter_start_block = 1'b1;
        tick(3);
        iter_start_block = 1'b0;
        tick(2);
        iter_start_enable = 1'b0;
        iter_start_block = 1'b1;
        tick(2);
        iter_start_block = 1'b0;
        cur_state = '0;
        checks++;
        if (stall_cycles !== exp_stall) begin
            errors++;
            $display("FAIL stall_cycles got %0d required %0d", stall_cycles, exp_stall);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        ap_m.ap_start = 1'b1;
        tick();
        ap_m.ap_start = 1'b0;
        ap_m.ap_done = 1'b1;
        tick();
        ap_m.ap_done = 1'b0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ap_m.ap_start = 1'b1;
            tick();
            ap_m.ap_start = 1'b0;
            ap_m.ap_done = 1'b1;
            tick();
            ap_m.ap_done = 1'b0;
        end
        checks++;
        if (txn_count !== 32'd1 || busy_cycles !== 32'd1 || module_busy !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold got txn=%0d busy_cyc=%0d busy=%b required txn=1 busy_cyc=1 busy=0",
                     txn_count, busy_cycles, module_busy);
        end
        do_reset();
        ap_m.ap_start = 1'b1;
        tick();
        ap_m.ap_start = 1'b0;
        ap_m.ap_done = 1'b1;
        tick();
        ap_m.ap_done = 1'b0;
        checks++;
        if (txn_count !== 32'd1) begin
            errors++;
            $display("FAIL freeze_cleared got txn=%0d required 1", txn_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            ap_s.ap_start = 1'b1;
            tick();
            ap_s.ap_start = 1'b0;
            ap_s.ap_done = 1'b1;
            tick();
            ap_s.ap_done = 1'b0;
        end
        checks++;
        if (s_txn_count !== 4'd15 || s_overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_txn got txn=%0d ovf=%b required txn=15 ovf=1", s_txn_count, s_overflow);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL main_no_overflow got %b required 0", overflow);
        end
        ap_s.ap_start = 1'b1;
        ap_m.ap_start = 1'b1;
        tick();
        ap_s.ap_start = 1'b0;
        ap_m.ap_start = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (module_busy !== 1'b0 || s_module_busy !== 1'b0 || s_txn_count !== 4'd0 ||
            s_overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got busy=%b s_busy=%b s_txn=%0d s_ovf=%b required all 0",
                     module_busy, s_module_busy, s_txn_count, s_overflow);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_txn();
        test_back_to_back();
        test_continue();
        test_pipelined_loop();
        test_quit_at_end();
        test_stall();
        test_freeze();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
